prog_stats: RTL and testbench

Downstream result-statistics stage for the `prog` datapath. It consumes the 8-bit `out` stream through a valid qualifier and accumulates fixed-size windows of WINDOW samples. For each window it presents min, max, sum and truncated average on a valid/ready result port. It sits between `prog` and the result sink, giving the sink a per-window summary instead of raw bytes.

---
 rtl/prog_stats_pkg.sv | 19 +
 rtl/prog_stats.sv | 104 ++++++++++
 tb/tb_prog_stats.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/prog_stats_pkg.sv
// Shared definitions for the prog_stats result-statistics stage:
// FSM state encodings and a constant log2 helper for deriving widths.
package prog_stats_pkg;

    // FSM states: collecting samples, or holding a finished window for the sink.
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // Ceiling log2, usable in constant expressions (parameter derivation).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_stats.sv
// prog_stats: per-window min/max/sum/average of the prog output stream.
// Samples arrive on a valid-only port (no backpressure); each completed
// window of WINDOW samples is presented on a valid/ready result port.
module prog_stats
    import prog_stats_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int WINDOW = 4,
    localparam int LW     = clog2(WINDOW),
    localparam int SW     = WIDTH + LW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             clear,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_min,
    output logic [WIDTH-1:0] res_max,
    output logic [SW-1:0]    res_sum,
    output logic [WIDTH-1:0] res_avg,
    output logic             overflow
);

    logic [0:0]       state;
    logic [LW-1:0]    cnt;
    logic [SW-1:0]    acc_sum;
    logic [WIDTH-1:0] acc_min;
    logic [WIDTH-1:0] acc_max;

    logic             accept;
    logic             drop;
    logic             last;
    logic [SW-1:0]    nxt_sum;
    logic [WIDTH-1:0] nxt_min;
    logic [WIDTH-1:0] nxt_max;

    // In HOLD a sample is taken only when the pending result leaves this cycle;
    // otherwise it has nowhere to go and is dropped.
    assign accept = in_valid && ((state == ST_ACCUM) || res_ready);
    assign drop   = in_valid && (state == ST_HOLD) && !res_ready;
    // cnt is always 0 in HOLD, so only an ACCUM sample can close a window.
    assign last   = accept && (cnt == LW'(WINDOW - 1));

    // Working values including the current sample; first sample seeds min/max.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt_sum = acc_sum + SW'(in_data);
        nxt_min = acc_min;
        nxt_max = acc_max;
        if (cnt == '0 || in_data < acc_min) nxt_min = in_data;
        if (cnt == '0 || in_data > acc_max) nxt_max = in_data;
    end

    // Result presentation: valid while holding, average is the truncated sum.
    assign res_valid = (state == ST_HOLD);
    assign res_avg   = res_sum[SW-1:LW];

    // Window accumulation, result capture, handshake and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state    <= ST_ACCUM;
            cnt      <= '0;
            acc_sum  <= '0;
            acc_min  <= '0;
            acc_max  <= '0;
            res_min  <= '0;
            res_max  <= '0;
            res_sum  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            // Abort the window; res_* data keeps the last delivered result.
            state    <= ST_ACCUM;
            cnt      <= '0;
            acc_sum  <= '0;
            acc_min  <= '0;
            acc_max  <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;

            if (state == ST_HOLD && res_ready) state <= ST_ACCUM;

            if (last) begin
                res_sum <= nxt_sum;
                res_min <= nxt_min;
                res_max <= nxt_max;
                state   <= ST_HOLD;
                cnt     <= '0;
                acc_sum <= '0;
                acc_min <= '0;
                acc_max <= '0;
            end else if (accept) begin
                cnt     <= cnt + 1'b1;
                acc_sum <= nxt_sum;
                acc_min <= nxt_min;
                acc_max <= nxt_max;
            end
        end
    end

endmodule

// File: tb/tb_prog_stats.sv
// Directed self-checking bench for prog_stats (WIDTH=8, WINDOW=4).
module tb_prog_stats;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       clear;
    logic       res_ready;
    logic       res_valid;
    logic [7:0] res_min;
    logic [7:0] res_max;
    logic [9:0] res_sum;
    logic [7:0] res_avg;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    prog_stats #(.WIDTH(8), .WINDOW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .clear     (clear),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_min   (res_min),
        .res_max   (res_max),
        .res_sum   (res_sum),
        .res_avg   (res_avg),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Observed result port packed as {valid, min, max, sum, avg}.
    function automatic logic [34:0] snap();
        return {res_valid, res_min, res_max, res_sum, res_avg};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:0] e;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; res_ready = 1'b1;
        #12;
        e = {1'b0, 8'd0, 8'd0, 10'd0, 8'd0};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL reset_result: got %h expected %h", snap(), e); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [34:0] e;
        res_ready = 1'b1;
        send(8'd40); send(8'd80); send(8'd120); send(8'd160);
        e = {1'b1, 8'd40, 8'd160, 10'd400, 8'd100};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL single_result: got %h expected %h", snap(), e); end
        step();
        n_cmp++;
        if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_one_cycle: got %b expected 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        logic [34:0] e;
        res_ready = 1'b1;
        send(8'd255); send(8'd255); send(8'd255); send(8'd255);
        e = {1'b1, 8'd255, 8'd255, 10'd1020, 8'd255};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL b2b_first: got %h expected %h", snap(), e); end
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        e = {1'b1, 8'd1, 8'd4, 10'd10, 8'd2};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL b2b_second: got %h expected %h", snap(), e); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
        step();
    endtask

    task automatic test_backpressure();
        logic [34:0] e;
        res_ready = 1'b0;
        send(8'd5); send(8'd6); send(8'd7); send(8'd8);
        send(8'd100); send(8'd200);
        e = {1'b1, 8'd5, 8'd8, 10'd26, 8'd6};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL bp_held_result: got %h expected %h", snap(), e); end
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_overflow_set: got %b expected 1", overflow); end
        res_ready = 1'b1;
        step();
        n_cmp++;
        if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_transfer: got %b expected 0", res_valid); end
        // A fresh window must start from cnt=0: dropped samples must not count.
        send(8'd2); send(8'd2); send(8'd2); send(8'd2);
        e = {1'b1, 8'd2, 8'd2, 10'd8, 8'd2};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL bp_next_window: got %h expected %h", snap(), e); end
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_overflow_sticky: got %b expected 1", overflow); end
        step();
    endtask

    task automatic test_handshake_accept();
        logic [34:0] e;
        res_ready = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        res_ready = 1'b1;
        send(8'd7);
        send(8'd9); send(8'd9); send(8'd9);
        e = {1'b1, 8'd7, 8'd9, 10'd34, 8'd8};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL handshake_accept: got %h expected %h", snap(), e); end
        step();
    endtask

    task automatic test_clear();
        logic [34:0] e;
        res_ready = 1'b1;
        send(8'd10); send(8'd20);
        clear = 1'b1;
        send(8'd30);
        clear = 1'b0;
        e = {1'b0, 8'd7, 8'd9, 10'd34, 8'd8};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL clear_keeps_data: got %h expected %h", snap(), e); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL clear_overflow: got %b expected 0", overflow); end
        send(8'd1); send(8'd1); send(8'd1);
        n_cmp++;
        if (res_valid !== 1'b0) begin n_bad++; $display("FAIL clear_no_early_result: got %b expected 0", res_valid); end
        send(8'd1);
        e = {1'b1, 8'd1, 8'd1, 10'd4, 8'd1};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL clear_fresh_window: got %h expected %h", snap(), e); end
        step();
    endtask

    task automatic test_async_reset();
        logic [34:0] e;
        res_ready = 1'b1;
        send(8'd3); send(8'd3); send(8'd3);
        #2 reset = 1'b1;
        #1;
        e = {1'b0, 8'd0, 8'd0, 10'd0, 8'd0};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL async_reset_outputs: got %h expected %h", snap(), e); end
        #2 reset = 1'b0;
        send(8'd50); send(8'd60); send(8'd70); send(8'd80);
        e = {1'b1, 8'd50, 8'd80, 10'd260, 8'd65};
        n_cmp++;
        if (snap() !== e) begin n_bad++; $display("FAIL async_reset_recovery: got %h expected %h", snap(), e); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_handshake_accept();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
